// File: rtl/iir_cascade_sequencer.sv
// Time-multiplexed Direct Form I biquad cascade sharing one 18x18 MAC, one pass per lr_clk rise.
// Define IIR_SAT_EN to saturate accumulator adds and the output shift; the default build wraps.
module iir_cascade_sequencer #(
    parameter int NUM_SECTIONS = 4,
    parameter int ADDR_W       = 6
) (
    input  logic                     state_clk,
    input  logic                     reset,
    input  logic                     lr_clk,
    input  logic signed [15:0]       audio_in,
    output logic        [ADDR_W-1:0] coef_addr,
    input  logic signed [17:0]       coef_data,
    output logic signed [15:0]       audio_out,
    output logic                     out_valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam int SW = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;
    localparam logic signed [17:0] SAT_MAX = 18'h1FFFF;
    localparam logic signed [17:0] SAT_MIN = 18'h20000;

    typedef enum logic [1:0] {IDLE, RUN, WB, OUT} state_t;

    state_t             state;
    logic               lr_q;
    logic [SW-1:0]      sec;
    logic [ADDR_W-1:0]  base;
    logic [2:0]         phase;
    logic [2:0]         scale;
    logic signed [17:0] x_in;
    logic signed [17:0] acc;
    logic signed [17:0] x1 [NUM_SECTIONS];
    logic signed [17:0] x2 [NUM_SECTIONS];
    logic signed [17:0] y1 [NUM_SECTIONS];
    logic signed [17:0] y2 [NUM_SECTIONS];

    logic               lr_rise;
    logic signed [17:0] operand;
    logic signed [35:0] product;
    logic signed [17:0] term;
    logic signed [17:0] acc_next;
    logic signed [17:0] y_shift;
    logic               product_unused;

    assign lr_rise = lr_clk & ~lr_q;

    // The coefficient for word k arrives two edges after its address, so phase k+1 consumes word k.
    always_comb begin
        operand = '0;
        case (phase)
            3'd1:    operand = x_in;
            3'd2:    operand = x1[sec];
            3'd3:    operand = x2[sec];
            3'd4:    operand = y1[sec];
            3'd5:    operand = y2[sec];
            default: operand = '0;
        endcase
    end

    assign product        = coef_data * operand;
    assign term           = {product[35], product[32:16]};
    assign product_unused = ^{product[34:33], product[15:0]};

`ifdef IIR_SAT_EN
    logic signed [18:0] sum_full;
    logic        [25:0] shifted;

    always_comb begin
        sum_full = {acc[17], acc} + {term[17], term};
        acc_next = sum_full[17:0];
        if (sum_full[18] != sum_full[17])
            acc_next = sum_full[18] ? SAT_MIN : SAT_MAX;
        shifted = {{8{acc[17]}}, acc} << scale;
        y_shift = shifted[17:0];
        if (shifted[25:17] != {9{shifted[17]}})
            y_shift = acc[17] ? SAT_MIN : SAT_MAX;
    end
`else
    always_comb begin
        acc_next = acc + term;
        y_shift  = acc <<< scale;
    end
`endif

    always_ff @(posedge state_clk) begin
        if (reset) begin
            state     <= IDLE;
            lr_q      <= 1'b0;
            sec       <= '0;
            base      <= '0;
            phase     <= '0;
            scale     <= '0;
            x_in      <= '0;
            acc       <= '0;
            coef_addr <= '0;
            audio_out <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < NUM_SECTIONS; i++) begin
                x1[i] <= '0;
                x2[i] <= '0;
                y1[i] <= '0;
                y2[i] <= '0;
            end
        end else begin
            lr_q      <= lr_clk;
            out_valid <= 1'b0;
            busy      <= (state == RUN) || (state == WB);
            if (lr_rise && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (lr_rise) begin
                        x_in      <= {audio_in, 2'b00};
                        sec       <= '0;
                        base      <= '0;
                        coef_addr <= '0;
                        phase     <= '0;
                        acc       <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (phase <= 3'd4)
                        coef_addr <= base + ADDR_W'(phase) + ADDR_W'(1);
                    if (phase >= 3'd1 && phase <= 3'd5)
                        acc <= acc_next;
                    if (phase == 3'd6) begin
                        scale <= coef_data[2:0];
                        state <= WB;
                    end
                    phase <= phase + 3'd1;
                end
                WB: begin
                    x2[sec] <= x1[sec];
                    x1[sec] <= x_in;
                    y2[sec] <= y1[sec];
                    y1[sec] <= y_shift;
                    x_in    <= y_shift;
                    if (sec == SW'(NUM_SECTIONS - 1)) begin
                        state <= OUT;
                    end else begin
                        sec       <= sec + SW'(1);
                        base      <= base + ADDR_W'(6);
                        coef_addr <= base + ADDR_W'(6);
                        acc       <= '0;
                        phase     <= '0;
                        state     <= RUN;
                    end
                end
                OUT: begin
                    audio_out <= x_in[17:2];
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_cascade_sequencer.sv
// Scoreboard bench for iir_cascade_sequencer: directed cases plus randomized samples against a
// sample-level reference model of the biquad cascade (honours IIR_SAT_EN).
module tb_iir_cascade_sequencer;

    localparam int N      = 4;
    localparam int ADDR_W = 6;
    localparam int LAT    = 8 * N + 1;

    logic                     state_clk = 1'b0;
    logic                     reset     = 1'b1;
    logic                     lr_clk    = 1'b0;
    logic signed [15:0]       audio_in  = '0;
    logic        [ADDR_W-1:0] coef_addr;
    logic signed [17:0]       coef_data = '0;
    logic signed [15:0]       audio_out;
    logic                     out_valid;
    logic                     busy;
    logic                     overrun;

    iir_cascade_sequencer #(.NUM_SECTIONS(N), .ADDR_W(ADDR_W)) dut (
        .state_clk(state_clk),
        .reset    (reset),
        .lr_clk   (lr_clk),
        .audio_in (audio_in),
        .coef_addr(coef_addr),
        .coef_data(coef_data),
        .audio_out(audio_out),
        .out_valid(out_valid),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 state_clk = ~state_clk;

    logic [17:0] ram [2**ADDR_W];
    always @(posedge state_clk) coef_data <= ram[coef_addr];

    int cycle = 0;
    always @(posedge state_clk) cycle <= cycle + 1;

    typedef struct {
        int value;
        int due;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int mx1[N], mx2[N], my1[N], my2[N];

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, required, cycle);
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest pending expectation, value and timing.
    always @(negedge state_clk) begin : monitor
        exp_t e;
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected out_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("audio_out", int'(audio_out), e.value);
                checkOutput("out_valid cycle", cycle, e.due);
            end
        end
    end

    function automatic longint limit18(input longint v);
`ifdef IIR_SAT_EN
        if (v > 131071)  return 131071;
        if (v < -131072) return -131072;
        return v;
`else
        longint m;
        m = v & 64'h3FFFF;
        return (m >= 131072) ? m - 262144 : m;
`endif
    endfunction

    function automatic longint mkTerm(input longint p);
        longint low;
        low = (p >>> 16) & 64'h1FFFF;
        return (p < 0) ? low - 131072 : low;
    endfunction

    function automatic longint coefVal(input int a);
        logic signed [17:0] w;
        w = ram[a];
        return longint'(w);
    endfunction

    function automatic int modelSample(input int sample);
        longint x, acc, y, p;
        longint ops[5];
        logic [17:0] sw;
        x = longint'(sample) * 4;
        for (int s = 0; s < N; s++) begin
            ops = '{x, longint'(mx1[s]), longint'(mx2[s]), longint'(my1[s]), longint'(my2[s])};
            acc = 0;
            for (int k = 0; k < 5; k++) begin
                p   = coefVal(6 * s + k) * ops[k];
                acc = limit18(acc + mkTerm(p));
            end
            sw = ram[6 * s + 5];
            y  = limit18(acc <<< sw[2:0]);
            mx2[s] = mx1[s];
            mx1[s] = int'(x);
            my2[s] = my1[s];
            my1[s] = int'(y);
            x = y;
        end
        return int'(x >>> 2);
    endfunction

    task automatic tick();
        @(posedge state_clk);
        #1;
    endtask

    task automatic loadSection(input int s, input int b1, input int b2, input int b3,
                               input int na2, input int na3, input int sc);
        int w[6];
        w = '{b1, b2, b3, na2, na3, sc};
        for (int k = 0; k < 6; k++) ram[6 * s + k] = w[k][17:0];
    endtask

    task automatic unityTail();
        for (int s = 1; s < N; s++) loadSection(s, 16384, 0, 0, 0, 0, 2);
    endtask

    task automatic applyReset();
        reset  = 1'b1;
        lr_clk = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        for (int s = 0; s < N; s++) begin
            mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
        end
    endtask

    // Raises lr_clk so the next edge detects it; leaves lr_clk high and returns at the detect edge.
    task automatic applyStimulus(input int sample, input bit expectOut, input bit useDirected,
                                 input int directed, output int det);
        exp_t e;
        int   m;
        audio_in = sample[15:0];
        lr_clk   = 1'b1;
        tick();
        det = cycle;
        if (expectOut) begin
            m       = modelSample(sample);
            e.value = useDirected ? directed : m;
            e.due   = det + LAT;
            sb.push_back(e);
        end
    endtask

    task automatic runSample(input int sample, input bit useDirected, input int directed,
                             input int hold, input int period);
        int det;
        applyStimulus(sample, 1'b1, useDirected, directed, det);
        repeat (hold - 1) tick();
        lr_clk = 1'b0;
        while (cycle < det + period - 1) tick();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " audio_out"}, int'(audio_out), 0);
        checkOutput({tag, " out_valid"}, int'(out_valid), 0);
        checkOutput({tag, " busy"}, int'(busy), 0);
        checkOutput({tag, " overrun"}, int'(overrun), 0);
        checkOutput({tag, " coef_addr"}, int'(coef_addr), 0);
    endtask

    initial begin
        int det;
        int c, a;
        for (int i = 0; i < 2**ADDR_W; i++) ram[i] = '0;

        applyReset();
        checkResetValues("reset");

        // Unity pass-through with busy window and coef_addr hold in IDLE.
        loadSection(0, 16384, 0, 0, 0, 0, 2);
        unityTail();
        applyStimulus(1000, 1'b1, 1'b1, 1000, det);
        tick();
        checkOutput("busy first cycle", int'(busy), 1);
        lr_clk = 1'b0;
        while (cycle < det + 8 * N) tick();
        checkOutput("busy last cycle", int'(busy), 1);
        tick();
        checkOutput("busy after run", int'(busy), 0);
        tick();
        checkOutput("coef_addr idle hold", int'(coef_addr), 6 * (N - 1) + 5);
        checkOutput("overrun clean", int'(overrun), 0);
        repeat (3) tick();

        // A level held high must not retrigger.
        runSample(500, 1'b1, 500, 60, 70);

        // Unit delay.
        applyReset();
        loadSection(0, 0, 16384, 0, 0, 0, 2);
        runSample(1000, 1'b1, 0, 1, 8 * N + 2);
        runSample(0, 1'b1, 1000, 2, 8 * N + 2);
        runSample(0, 1'b1, 0, 1, 8 * N + 3);

        // Feedback decay.
        applyReset();
        loadSection(0, 16384, 0, 0, 8192, 0, 2);
        runSample(1000, 1'b1, 1000, 1, 8 * N + 2);
        runSample(0, 1'b1, 500, 1, 8 * N + 2);
        runSample(0, 1'b1, 250, 1, 8 * N + 2);
        runSample(0, 1'b1, 125, 1, 8 * N + 2);

        // Saturation versus wrap.
        applyReset();
        loadSection(0, 65536, 0, 0, 0, 0, 2);
`ifdef IIR_SAT_EN
        runSample(20000, 1'b1, 32767, 1, 8 * N + 2);
`else
        runSample(20000, 1'b1, 14464, 1, 8 * N + 2);
`endif

        // Overrun mid-run: ignored rise, no restart, sticky flag.
        applyReset();
        loadSection(0, 16384, 0, 0, 0, 0, 2);
        applyStimulus(1000, 1'b1, 1'b1, 1000, det);
        tick();
        lr_clk = 1'b0;
        while (cycle < det + 19) tick();
        lr_clk   = 1'b1;
        audio_in = 16'sd7;
        tick();
        checkOutput("overrun set", int'(overrun), 1);
        lr_clk = 1'b0;
        while (cycle < det + 39) tick();
        runSample(300, 1'b1, 300, 1, 8 * N + 2);
        checkOutput("overrun sticky", int'(overrun), 1);

        // Reset mid-run aborts the sample and clears history.
        applyReset();
        loadSection(0, 0, 16384, 0, 0, 0, 2);
        applyStimulus(1000, 1'b0, 1'b0, 0, det);
        tick();
        lr_clk = 1'b0;
        while (cycle < det + 11) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int s = 0; s < N; s++) begin
            mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
        end
        checkResetValues("midrun reset");
        repeat (40) tick();
        runSample(0, 1'b1, 0, 1, 8 * N + 2);

        // A rise landing in the OUT cycle is an overrun; the rise after it is accepted.
        applyStimulus(200, 1'b1, 1'b1, 0, det);
        tick();
        lr_clk = 1'b0;
        while (cycle < det + 8 * N) tick();
        lr_clk = 1'b1;
        tick();
        checkOutput("overrun at OUT", int'(overrun), 1);
        lr_clk = 1'b0;
        while (cycle < det + 39) tick();
        runSample(0, 1'b1, 200, 1, 8 * N + 2);

        // Randomized cascade against the reference model.
        applyReset();
        for (int s = 0; s < N; s++) begin
            for (int k = 0; k < 5; k++) begin
                c = int'($urandom_range(0, 65536)) - 32768;
                ram[6 * s + k] = c[17:0];
            end
            ram[6 * s + 5] = 18'($urandom_range(0, 3));
        end
        for (int i = 0; i < 25; i++) begin
            a = int'($urandom_range(0, 65535)) - 32768;
            runSample(a, 1'b0, 0, int'($urandom_range(1, 5)), int'($urandom_range(8 * N + 2, 8 * N + 8)));
        end

        for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
        checkOutput("scoreboard drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iir_cascade_sequencer.md
# iir_cascade_sequencer

Time-multiplexed controller that evaluates a cascade of NUM_SECTIONS second-order IIR sections (Direct Form I, 2.16 fixed point) on one shared 18x18 MAC, once per audio sample. It sits between the codec sample path and an external coefficient RAM. It one-shots the audio frame clock, fetches the coefficients and per-section shift, sequences the MAC, and keeps per-section input/output history. The output of section s feeds section s+1.

## Interface
- NUM_SECTIONS, 4, number of cascaded biquads (1..8).
- ADDR_W, 6, coefficient RAM address width; must satisfy 6*NUM_SECTIONS <= 2^ADDR_W.
- state_clk  in  1  fast processing clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- lr_clk  in  1  audio frame clock, synchronous to state_clk; its rising edge starts a sample.
- audio_in  in  16  signed input sample.
- coef_addr  out  ADDR_W  registered coefficient RAM read address.
- coef_data  in  18  signed coefficient, valid one state_clk cycle after coef_addr.
- audio_out  out  16  signed filtered sample.
- out_valid  out  1  one-cycle pulse when audio_out updates.
- busy  out  1  high while a sample is being processed.
- overrun  out  1  sticky; set when an lr_clk rising edge arrives while busy.

## Operation
- RAM layout per section s, at base address 6s: +0 b1, +1 b2, +2 b3, +3 −a2, +4 −a3, +5 scale (bits [2:0], 0..7). The feedback terms are stored pre-negated, so the MAC always adds.
- States:
  - IDLE: on rising edge of lr_clk (lr_q==0, lr_clk==1), latch x = {audio_in, 2'b00} and go to RUN with s=0, k=0.
  - RUN: issue coef_addr = 6s+k for k=0..5. One cycle later, MAC the returned coefficient with operand k: x_in, x1[s], x2[s], y1[s], y2[s]. Word k=5 loads the shift instead of doing a MAC.
  - WB: compute y = acc << scale. Update history: x2[s]<=x1[s], x1[s]<=x_in, y2[s]<=y1[s], y1[s]<=y. The next section's x_in is y. If s==NUM_SECTIONS−1, go to OUT; otherwise increment s, clear acc and return to RUN.
  - OUT: audio_out <= y[17:2], pulse out_valid, return to IDLE.
- Product arithmetic: p = coef * operand is 36-bit signed. The 18-bit term is {p[35], p[32:16]} (2.16 format).
- Accumulator: 18-bit, cleared at the start of each section. Without the saturation macro, additions and the shift wrap modulo 2^18.
- Overrun: a rising edge of lr_clk outside IDLE is ignored (no restart, no queue) and sets overrun. overrun clears only on reset.
- Edge detect: lr_q updates every cycle in every state. A level held high never retriggers.
- Reset mid-run: the sample is aborted and no out_valid is produced. All history is zeroed.
- Reset values: audio_out 0, out_valid 0, busy 0, overrun 0, coef_addr 0; state IDLE, acc 0, all x1/x2/y1/y2 0, lr_q 0.

## Timing
- Cycle 0 is the state_clk edge that detects the lr_clk rise.
- Each section takes 8 cycles: 6 address cycles, 1 final-data cycle, 1 WB.
- busy is high in cycles 1..8·NUM_SECTIONS.
- audio_out and out_valid are registered at cycle 8·NUM_SECTIONS+1. Latency is 33 cycles for NUM_SECTIONS=4.
- coef_addr holds its last value while IDLE.
- Minimum lr_clk period: 8·NUM_SECTIONS+2 state_clk cycles. A shorter period produces overrun.
- An lr_clk rise in the same cycle as the OUT state is ignored and counts as an overrun. An lr_clk rise in the first IDLE cycle is accepted.

## Configuration
- IIR_SAT_EN defined: each accumulator add and the final shift saturate to [−131072, +131071]. The shift saturates if any bit shifted out differs from the sign bit.
- IIR_SAT_EN undefined: plain two's-complement wrap, with no extra logic.

## Test plan
- Unity pass-through: NUM_SECTIONS=1, b1=16384 (0.25), other coefficients 0, scale=2; audio_in=1000. Required: audio_out=1000 with out_valid at cycle 9, busy high for cycles 1..8.
- Unit delay: b2=16384 only, scale=2; samples 1000, 0, 0. Required: outputs 0, 1000, 0.
- Feedback decay: b1=16384, −a2 word=8192 (0.125), scale=2; impulse 1000 then zeros. Required: outputs 1000, 500, 250, 125.
- Saturation: b1=65536 (1.0), scale=2, audio_in=20000. Required: 32767 with IIR_SAT_EN defined; 14464 without it.
- Overrun: NUM_SECTIONS=4; second lr_clk rise at cycle 20. Required: overrun=1, exactly one out_valid at cycle 33, no restart. The next rise after IDLE processes normally and overrun stays 1.
- Reset mid-run: assert reset at cycle 12 of a sample. Required: no out_valid; all outputs at reset values. The next sample with the unit-delay coefficients returns 0, proving the history was cleared.
